// File: rtl/tl_pkg.sv
// Shared types and helpers for the lamp conflict monitor: lamp decode, transition legality,
// fault codes and monitor FSM states.
package tl_pkg;

    typedef enum logic [2:0] {
        RED     = 3'd0,
        LEFT    = 3'd1,
        GREEN   = 3'd2,
        YELLOW  = 3'd3,
        INVALID = 3'd4
    } lamp_state_t;

    typedef enum logic [1:0] {
        ARM   = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } mon_state_t;

    typedef logic [2:0] fault_code_t;

    localparam fault_code_t F_NONE     = 3'd0;
    localparam fault_code_t F_CONFLICT = 3'd1;
    localparam fault_code_t F_INVALID  = 3'd2;
    localparam fault_code_t F_SEQ      = 3'd3;
    localparam fault_code_t F_SHORT_Y  = 3'd4;
    localparam fault_code_t F_WDOG     = 3'd5;

    // Lamp bit order is {LeftTurn, Green, Yellow, Red}; anything not one-hot is INVALID.
    function automatic lamp_state_t decode_lamps(input logic [3:0] lamps);
        lamp_state_t st;
        case (lamps)
            4'b0001: st = RED;
            4'b0010: st = YELLOW;
            4'b0100: st = GREEN;
            4'b1000: st = LEFT;
            default: st = INVALID;
        endcase
        return st;
    endfunction

    function automatic logic legal_step(input lamp_state_t prev, input lamp_state_t cur);
        logic ok;
        ok = 1'b0;
        case (prev)
            RED:     ok = (cur == LEFT) || (cur == GREEN);
            LEFT:    ok = (cur == GREEN) || (cur == YELLOW);
            GREEN:   ok = (cur == YELLOW);
            YELLOW:  ok = (cur == RED);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lamp_tracker.sv
// Per-direction lamp tracker: decodes the registered lamp bits and checks transition
// legality, yellow duration and hold watchdog; counts completed phase cycles.
module lamp_tracker
    import tl_pkg::*;
#(
    parameter int unsigned MIN_YELLOW = 3,
    parameter int unsigned MAX_HOLD   = 64,
    parameter int unsigned TIMER_W    = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [3:0]        i_lamps,
    input  logic              i_en,
    input  logic              i_arm,
    input  logic              i_cnt_en,
    output lamp_state_t       o_state,
    output logic              o_seq_err,
    output logic              o_short_y,
    output logic              o_wdog,
    output logic [CNT_W-1:0]  o_count
);

    localparam logic [TIMER_W-1:0] T_ONE      = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] HOLD_LIMIT = TIMER_W'(MAX_HOLD + 1);
    localparam logic [TIMER_W-1:0] YEL_MIN    = TIMER_W'(MIN_YELLOW);
    localparam logic [TIMER_W-1:0] YEL_SAT    = {TIMER_W{1'b1}};
    localparam logic [CNT_W-1:0]   C_ONE      = CNT_W'(1);

    lamp_state_t        w_state;
    lamp_state_t        r_prev;
    logic [TIMER_W-1:0] r_hold;
    logic [TIMER_W-1:0] w_hold_d;
    logic [TIMER_W-1:0] r_yel;
    logic [TIMER_W-1:0] w_yel_d;
    logic [CNT_W-1:0]   r_count;
    logic               w_changed;
    logic               w_yel_to_red;
    logic               w_phase_done;

    always_comb begin
        w_state = decode_lamps(i_lamps);
        // The arming cycle has no meaningful previous state, so treat it as a fresh entry.
        w_changed    = i_arm || (w_state != r_prev);
        w_yel_to_red = !i_arm && (r_prev == YELLOW) && (w_state == RED);

        if (w_changed) begin
            w_hold_d = T_ONE;
        end else if (r_hold == HOLD_LIMIT) begin
            w_hold_d = r_hold;
        end else begin
            w_hold_d = r_hold + T_ONE;
        end

        if (w_state != YELLOW) begin
            w_yel_d = '0;
        end else if (w_changed) begin
            w_yel_d = T_ONE;
        end else if (r_yel == YEL_SAT) begin
            w_yel_d = r_yel;
        end else begin
            w_yel_d = r_yel + T_ONE;
        end

        w_phase_done = i_cnt_en && w_yel_to_red && (r_yel >= YEL_MIN);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev  <= RED;
            r_hold  <= '0;
            r_yel   <= '0;
            r_count <= '0;
        end else if (i_en) begin
            r_prev <= w_state;
            r_hold <= w_hold_d;
            r_yel  <= w_yel_d;
            if (w_phase_done) begin
                r_count <= r_count + C_ONE;
            end
        end
    end

    always_comb begin
        o_state   = w_state;
        o_seq_err = !i_arm && (w_state != r_prev) && !legal_step(r_prev, w_state);
        o_short_y = w_yel_to_red && (r_yel < YEL_MIN);
        o_wdog    = !i_arm && (w_hold_d == HOLD_LIMIT);
        o_count   = r_count;
    end

endmodule

// File: rtl/light_conflict_monitor.sv
// Lamp-interface safety monitor: registers both directions' lamps, checks conflicts and
// per-direction rules, and latches the first violation as a sticky fault.
module light_conflict_monitor
    import tl_pkg::*;
#(
    parameter int unsigned MIN_YELLOW = 3,
    parameter int unsigned MAX_HOLD   = 64,
    parameter int unsigned TIMER_W    = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             LeftTurn_NS,
    input  logic             Green_NS,
    input  logic             Yellow_NS,
    input  logic             Red_NS,
    input  logic             LeftTurn_EW,
    input  logic             Green_EW,
    input  logic             Yellow_EW,
    input  logic             Red_EW,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic             emergency_req,
    output logic [CNT_W-1:0] cycles_ns,
    output logic [CNT_W-1:0] cycles_ew
);

    logic [3:0]       r_lamps_ns;
    logic [3:0]       r_lamps_ew;
    logic             r_vld;
    mon_state_t       r_state;
    mon_state_t       w_state_d;
    fault_code_t      r_code;
    fault_code_t      w_code;
    lamp_state_t      w_st_ns;
    lamp_state_t      w_st_ew;
    logic             w_seq_ns;
    logic             w_seq_ew;
    logic             w_short_ns;
    logic             w_short_ew;
    logic             w_wdog_ns;
    logic             w_wdog_ew;
    logic             w_arm;
    logic             w_run;
    logic             w_trk_en;
    logic             w_cnt_en;
    logic             w_conflict;
    logic             w_invalid;
    logic [CNT_W-1:0] w_cnt_ns;
    logic [CNT_W-1:0] w_cnt_ew;

    // r_vld marks the first cycle whose sample holds real lamp data rather than reset zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lamps_ns <= '0;
            r_lamps_ew <= '0;
            r_vld      <= 1'b0;
        end else begin
            r_lamps_ns <= {LeftTurn_NS, Green_NS, Yellow_NS, Red_NS};
            r_lamps_ew <= {LeftTurn_EW, Green_EW, Yellow_EW, Red_EW};
            r_vld      <= 1'b1;
        end
    end

    always_comb begin
        w_arm    = (r_state == ARM) && r_vld;
        w_run    = (r_state == RUN);
        w_trk_en = w_arm || w_run;
        w_cnt_en = w_run && (w_code == F_NONE);
    end

    lamp_tracker #(
        .MIN_YELLOW (MIN_YELLOW),
        .MAX_HOLD   (MAX_HOLD),
        .TIMER_W    (TIMER_W),
        .CNT_W      (CNT_W)
    ) u_trk_ns (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_lamps   (r_lamps_ns),
        .i_en      (w_trk_en),
        .i_arm     (w_arm),
        .i_cnt_en  (w_cnt_en),
        .o_state   (w_st_ns),
        .o_seq_err (w_seq_ns),
        .o_short_y (w_short_ns),
        .o_wdog    (w_wdog_ns),
        .o_count   (w_cnt_ns)
    );

    lamp_tracker #(
        .MIN_YELLOW (MIN_YELLOW),
        .MAX_HOLD   (MAX_HOLD),
        .TIMER_W    (TIMER_W),
        .CNT_W      (CNT_W)
    ) u_trk_ew (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_lamps   (r_lamps_ew),
        .i_en      (w_trk_en),
        .i_arm     (w_arm),
        .i_cnt_en  (w_cnt_en),
        .o_state   (w_st_ew),
        .o_seq_err (w_seq_ew),
        .o_short_y (w_short_ew),
        .o_wdog    (w_wdog_ew),
        .o_count   (w_cnt_ew)
    );

    // Lowest code wins; the arming cycle only sees the conflict and encoding checks.
    always_comb begin
        w_invalid  = (w_st_ns == INVALID) || (w_st_ew == INVALID);
        w_conflict = (w_st_ns != RED) && (w_st_ew != RED) && !w_invalid;
        w_code     = F_NONE;
        if (w_arm || w_run) begin
            if (w_conflict) begin
                w_code = F_CONFLICT;
            end else if (w_invalid) begin
                w_code = F_INVALID;
            end else if (w_run && (w_seq_ns || w_seq_ew)) begin
                w_code = F_SEQ;
            end else if (w_run && (w_short_ns || w_short_ew)) begin
                w_code = F_SHORT_Y;
            end else if (w_run && (w_wdog_ns || w_wdog_ew)) begin
                w_code = F_WDOG;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARM;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            ARM: begin
                if (r_vld) begin
                    w_state_d = (w_code != F_NONE) ? FAULT : RUN;
                end
            end
            RUN: begin
                if (w_code != F_NONE) begin
                    w_state_d = FAULT;
                end
            end
            FAULT:   w_state_d = FAULT;
            default: w_state_d = FAULT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_code <= F_NONE;
        end else if ((w_arm || w_run) && (w_code != F_NONE)) begin
            r_code <= w_code;
        end
    end

    always_comb begin
        fault         = (r_state == FAULT);
        fault_code    = r_code;
        emergency_req = fault;
        cycles_ns     = w_cnt_ns;
        cycles_ew     = w_cnt_ew;
    end

endmodule

// File: doc/light_conflict_monitor.md
Name: light_conflict_monitor

Overview:
- Receiving end of the controller's lamp interface: samples the eight lamp lines (LeftTurn/Green/Yellow/Red for NS and EW) each clock and checks them against safety rules.
- On the first violation it latches a sticky fault with a code and raises emergency_req, which the top level ORs into the controllers' emergency input.
- Also counts completed phase cycles per direction for status and debug.

Parameters:
- MIN_YELLOW, 3: minimum consecutive cycles a yellow lamp must be held before leaving yellow.
- MAX_HOLD, 64: watchdog limit; maximum consecutive cycles any single lamp state may persist.
- TIMER_W, 8: width of the yellow and hold timers; must hold MAX_HOLD+1.
- CNT_W, 16: width of the phase-cycle counters.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- LeftTurn_NS, Green_NS, Yellow_NS, Red_NS  in  1 each  NS lamp lines.
- LeftTurn_EW, Green_EW, Yellow_EW, Red_EW  in  1 each  EW lamp lines.
- fault  out  1  sticky violation flag.
- fault_code  out  3  first violation detected (0 = none).
- emergency_req  out  1  equals fault; drives controller emergency.
- cycles_ns  out  CNT_W  count of NS YELLOW->RED transitions.
- cycles_ew  out  CNT_W  count of EW YELLOW->RED transitions.

Behaviour:
- Reset (async, any time, including mid-fault): fault=0, fault_code=0, emergency_req=0, cycles_ns=cycles_ew=0, timers=0, FSM=ARM, sample registers cleared.
- Input path: lamp lines are registered once. Each direction's registered 4 bits decode to exactly one lamp state: RED, LEFT, GREEN, YELLOW. Zero or more than one active bit decodes to INVALID.
- Latency: a violating input present before posedge k gives fault=1 after posedge k+1.
- FSM states:
  - ARM: first cycle after reset. Captures the previous-state registers. Only the conflict check (code 1) and invalid-encoding check (code 2) apply. Goes to RUN unconditionally unless a fault is detected.
  - RUN: all checks active.
  - FAULT: absorbing; left only by rst. Counters and timers freeze. fault_code holds.
- Checks, evaluated on registered states each cycle in RUN:
  - Code 1, conflict: neither direction is RED, and neither direction is INVALID.
  - Code 2, invalid: either direction is INVALID.
  - Code 3, illegal transition: a state change other than RED->LEFT, RED->GREEN, LEFT->GREEN, LEFT->YELLOW, GREEN->YELLOW, YELLOW->RED.
  - Code 4, short yellow: YELLOW->RED with the yellow timer < MIN_YELLOW.
  - Code 5, watchdog: the hold timer reaches MAX_HOLD+1, i.e. the state has been unchanged for more than MAX_HOLD cycles.
- Simultaneous violations, within or across directions: the lowest code wins. Only the first violation is latched; later ones are ignored.
- Timers, per direction:
  - Hold timer resets to 1 on any state change, else increments, saturating at MAX_HOLD+1.
  - Yellow timer counts consecutive YELLOW cycles (1 on entry), saturates at its maximum, and clears on leaving YELLOW.
- Phase counters: increment on a legal YELLOW->RED with yellow timer >= MIN_YELLOW. Wrap modulo 2^CNT_W; no overflow flag.
- emergency_req is combinationally equal to the fault register (no extra delay).

Decomposition:
- Shared package tl_pkg: lamp_state_t enum (RED, LEFT, GREEN, YELLOW, INVALID); fault code constants F_NONE=0, F_CONFLICT=1, F_INVALID=2, F_SEQ=3, F_SHORT_Y=4, F_WDOG=5; monitor FSM enum (ARM, RUN, FAULT).
- Sub-module lamp_tracker, instantiated per direction. Contains the 4-bit decode, previous-state register, transition legality, yellow and hold timers, and phase counter. Outputs state, seq_err, short_y, wdog, and count.
- Top level holds the conflict check, priority encoder and FSM.

Test Plan:
1. Legal sequences, MIN_YELLOW=3, MAX_HOLD=64. NS runs R->L->G->Y(3 cycles)->R while EW holds RED, then EW runs the same while NS holds RED, 4 full rounds -> fault stays 0, cycles_ns=4, cycles_ew=4.
2. Conflict: NS=GREEN and EW=GREEN driven together for one cycle at posedge k -> fault=1 and fault_code=1 after posedge k+1; emergency_req=1 in the same cycle.
3. Invalid and priority: NS drives Green and Red together while EW is GREEN -> fault_code=2 (conflict suppressed because NS is INVALID). A separate run with all NS lamps off -> fault_code=2.
4. Sequence and yellow: NS GREEN->RED directly -> fault_code=3. After rst, NS GREEN->YELLOW held 2 cycles ->RED -> fault_code=4, cycles_ns unchanged at 0.
5. Watchdog: both directions held RED for 65 cycles after ARM -> fault_code=5 on the cycle the hold timer hits 65. A further conflict injected afterwards leaves fault_code=5.
6. Reset mid-fault: assert rst asynchronously between clock edges while fault=1 -> all outputs 0 immediately. A legal sequence afterwards runs with no fault, and counters restart from 0.
